comp_table_arbiter: RTL
=======================

Name: comp_table_arbiter

Overview:
- Time-shares one single-ported compression dictionary (one field table) among three requesters.
  - Decompress lookups: key to value, from the compressed-cache read path.
  - Compress lookups: value to key, from the icache-fill path.
  - Configuration writes: dictionary loading.
- Sits between the cache controller and each field table; one instance per field.
- Enforces load/run sequencing.
- Keeps compress lookups from starving behind decompress traffic.

Parameters:
- IDX_W, 8, dictionary index/key width.
- VAL_W, 15, dictionary value width.
- STARVE_LIMIT, 4, consecutive cycles a compress request may lose before it is forced to win (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dec_req_valid  in  1  decompress lookup request
- dec_req_key  in  IDX_W  key to look up
- dec_req_ready  out  1  decompress request accepted this cycle
- dec_resp_valid  out  1  decompress result valid
- dec_resp_val  out  VAL_W  value read at key
- cmp_req_valid  in  1  compress lookup request
- cmp_req_val  in  VAL_W  value to match
- cmp_req_ready  out  1  compress request accepted this cycle
- cmp_resp_valid  out  1  compress result valid
- cmp_resp_hit  out  1  value present in table
- cmp_resp_key  out  IDX_W  matching key (valid when hit)
- cfg_load_start  in  1  enter load mode
- cfg_load_done  in  1  leave load mode
- cfg_wr_valid  in  1  table write request
- cfg_wr_idx  in  IDX_W  write index
- cfg_wr_val  in  VAL_W  write value
- cfg_wr_ready  out  1  write accepted this cycle
- loading  out  1  high in LOAD or FLUSH
- tbl_en  out  1  table operation this cycle
- tbl_op  out  2  00 read key, 01 match value, 10 write
- tbl_idx  out  IDX_W  key/index to table
- tbl_val  out  VAL_W  match/write value to table
- tbl_rdata  in  VAL_W  read result, one cycle after tbl_en
- tbl_hit  in  1  match result, one cycle after tbl_en
- tbl_hit_idx  in  IDX_W  matching index, one cycle after tbl_en

Behaviour:
- Handshake: a request transfers when valid && ready in the same cycle. Ready signals are combinational from state, valids and the starvation counter.
- Request stability: a requester holds its valid and payload until accepted.
- Table drive: tbl_* are combinational from the winning request; tbl_en = any grant. At most one grant per cycle.
- Response timing: the response is delivered exactly 1 cycle after acceptance.
  - resp_valid is a registered 1-cycle pulse.
  - resp data passes combinationally from tbl_rdata, tbl_hit and tbl_hit_idx.
  - There is no response backpressure.
  - Back-to-back accepts give back-to-back responses.
- FSM states:
  - RUN: only lookups granted; cfg_wr_ready = 0.
  - LOAD: only writes granted; cfg_wr_ready = cfg_wr_valid; lookup readys = 0.
  - FLUSH: 1 cycle; no grants; lets the final write settle before lookups resume.
- FSM transitions:
  - RUN to LOAD on cfg_load_start, effective the next cycle. A lookup accepted in the start cycle still completes, and its response still appears.
  - LOAD to FLUSH on cfg_load_done. A write with valid in the done cycle is accepted.
  - FLUSH to RUN unconditionally.
  - cfg_load_start outside RUN is ignored. cfg_load_done outside LOAD is ignored.
- RUN arbitration:
  - Decompress has priority over compress.
  - starve_cnt (4 bits) increments each cycle cmp_req_valid is high and compress is not granted.
  - starve_cnt clears when compress is granted, and when cmp_req_valid is low.
  - When starve_cnt == STARVE_LIMIT, compress wins over decompress. The counter saturates and does not wrap.
  - starve_cnt is held (not incremented) outside RUN.
- Reset: state = RUN, starve_cnt = 0, dec_resp_valid = cmp_resp_valid = 0, loading = 0.
  - All readys and tbl_en are 0 during the reset cycle.
  - Reset mid-operation drops any in-flight response: no resp_valid in the cycle after reset.
  - Reset aborts LOAD/FLUSH and returns to RUN.

Optional Feature:
- Macro: COMP_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_dec_grants, perf_cmp_grants and perf_cmp_forced, each 32 bits.
  - perf_cmp_forced counts grants won through starvation.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
  - Input perf_clr (1 bit) clears all three counters synchronously. perf_clr has priority over an increment in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single decompress, key 0x05, table returns 0x1ABC: dec_req_ready = 1 same cycle, tbl_op = 00, tbl_idx = 0x05; next cycle dec_resp_valid = 1, dec_resp_val = 0x1ABC.
- Both requesters valid continuously, STARVE_LIMIT = 4: decompress granted cycles 0–3, compress granted cycle 4, decompress resumes cycle 5; cmp_resp_valid in cycle 5.
- Load sequence: cfg_load_start, 3 writes (idx 0/1/2, vals 0x0013/0x0033/0x0063), cfg_load_done with a 4th write pending: all 4 writes accepted (tbl_op = 10); loading high through FLUSH; dec_req_ready = 0 until 2 cycles after done.
- Lookup held during LOAD: dec_req_valid held high throughout; accepted on the first RUN cycle after FLUSH; exactly one response.
- Compress miss, tbl_hit = 0: cmp_resp_valid = 1, cmp_resp_hit = 0; starve_cnt clears after grant.
- Reset asserted the cycle after a dec accept: no dec_resp_valid; state RUN; starve_cnt = 0; with COMP_ARB_PERF_CNT_EN, perf counters read 0.

Source files
------------

// File: rtl/comp_table_arbiter.sv
// Time-shares one single-ported field dictionary among decompress lookups, compress lookups and config writes.
// Optional performance counters are enabled with the COMP_ARB_PERF_CNT_EN macro.
module comp_table_arbiter #(
  parameter int IDX_W        = 8,
  parameter int VAL_W        = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_req_valid,
  input  logic [IDX_W-1:0] dec_req_key,
  output logic             dec_req_ready,
  output logic             dec_resp_valid,
  output logic [VAL_W-1:0] dec_resp_val,
  input  logic             cmp_req_valid,
  input  logic [VAL_W-1:0] cmp_req_val,
  output logic             cmp_req_ready,
  output logic             cmp_resp_valid,
  output logic             cmp_resp_hit,
  output logic [IDX_W-1:0] cmp_resp_key,
  input  logic             cfg_load_start,
  input  logic             cfg_load_done,
  input  logic             cfg_wr_valid,
  input  logic [IDX_W-1:0] cfg_wr_idx,
  input  logic [VAL_W-1:0] cfg_wr_val,
  output logic             cfg_wr_ready,
  output logic             loading,
  output logic             tbl_en,
  output logic [1:0]       tbl_op,
  output logic [IDX_W-1:0] tbl_idx,
  output logic [VAL_W-1:0] tbl_val,
  input  logic [VAL_W-1:0] tbl_rdata,
  input  logic             tbl_hit,
  input  logic [IDX_W-1:0] tbl_hit_idx
`ifdef COMP_ARB_PERF_CNT_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      perf_dec_grants,
  output logic [31:0]      perf_cmp_grants,
  output logic [31:0]      perf_cmp_forced
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_FLUSH} state_e;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_MATCH = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       dec_resp_q, dec_resp_d;
  logic       cmp_resp_q, cmp_resp_d;
  logic       dec_gnt, cmp_gnt, wr_gnt, cmp_forced;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    starve_d   = starve_q;
    dec_gnt    = 1'b0;
    cmp_gnt    = 1'b0;
    wr_gnt     = 1'b0;
    cmp_forced = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          cmp_forced = cmp_req_valid && (starve_q == LIMIT);
          cmp_gnt    = cmp_req_valid && (cmp_forced || !dec_req_valid);
          dec_gnt    = dec_req_valid && !cmp_gnt;
          if (!cmp_req_valid || cmp_gnt) begin
            starve_d = 4'd0;
          end else if (starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
          end
          if (cfg_load_start) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          wr_gnt = cfg_wr_valid;
          if (cfg_load_done) state_d = ST_FLUSH;
        end
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
    dec_resp_d = dec_gnt;
    cmp_resp_d = cmp_gnt;
  end

  // The single winner steers the table port; at most one grant is ever high.
  always_comb begin
    tbl_op  = OP_READ;
    tbl_idx = '0;
    tbl_val = '0;
    if (dec_gnt) begin
      tbl_op  = OP_READ;
      tbl_idx = dec_req_key;
    end else if (cmp_gnt) begin
      tbl_op  = OP_MATCH;
      tbl_val = cmp_req_val;
    end else if (wr_gnt) begin
      tbl_op  = OP_WRITE;
      tbl_idx = cfg_wr_idx;
      tbl_val = cfg_wr_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      starve_q   <= 4'd0;
      dec_resp_q <= 1'b0;
      cmp_resp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      dec_resp_q <= dec_resp_d;
      cmp_resp_q <= cmp_resp_d;
    end
  end

  assign dec_req_ready  = dec_gnt;
  assign cmp_req_ready  = cmp_gnt;
  assign cfg_wr_ready   = wr_gnt;
  assign tbl_en         = dec_gnt | cmp_gnt | wr_gnt;
  assign loading        = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
  assign dec_resp_valid = dec_resp_q;
  assign dec_resp_val   = tbl_rdata;
  assign cmp_resp_valid = cmp_resp_q;
  assign cmp_resp_hit   = tbl_hit;
  assign cmp_resp_key   = tbl_hit_idx;

`ifdef COMP_ARB_PERF_CNT_EN
  logic [31:0] perf_dec_q, perf_dec_d;
  logic [31:0] perf_cmp_q, perf_cmp_d;
  logic [31:0] perf_frc_q, perf_frc_d;

  // Saturating counters; a clear request wins over an increment in the same cycle.
  always_comb begin
    perf_dec_d = perf_dec_q;
    perf_cmp_d = perf_cmp_q;
    perf_frc_d = perf_frc_q;
    if (perf_clr) begin
      perf_dec_d = '0;
      perf_cmp_d = '0;
      perf_frc_d = '0;
    end else begin
      if (dec_gnt && (perf_dec_q != '1)) perf_dec_d = perf_dec_q + 32'd1;
      if (cmp_gnt && (perf_cmp_q != '1)) perf_cmp_d = perf_cmp_q + 32'd1;
      if (cmp_forced && (perf_frc_q != '1)) perf_frc_d = perf_frc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_dec_q <= '0;
      perf_cmp_q <= '0;
      perf_frc_q <= '0;
    end else begin
      perf_dec_q <= perf_dec_d;
      perf_cmp_q <= perf_cmp_d;
      perf_frc_q <= perf_frc_d;
    end
  end

  assign perf_dec_grants = perf_dec_q;
  assign perf_cmp_grants = perf_cmp_q;
  assign perf_cmp_forced = perf_frc_q;
`endif

endmodule
